count_enable_gen: RTL and testbench
===================================

// Module: count_enable_gen
// PURPOSE
//  Upstream enable sequencer for the 4-bit counter stage. Drives its enable input with
//  single-cycle pulses at a programmable rate, for a programmable number of pulses or
//  continuously. The counter therefore advances at a controlled, bounded rate instead of
//  once per clock. Start and stop are single-cycle commands; busy and done report status.
// PARAMETERS
//  DIV_W  8  width of the prescale divisor; pulse period = div+1 clocks
//  LEN_W  5  width of the burst length; 0 = run until stop, max 2**LEN_W-1 pulses
// PORTS
//  clock   in   1      single clock; all logic on posedge
//  reset   in   1      synchronous, active-high; overrides every other input
//  start   in   1      command: latch div/len and begin sequence (honoured only in IDLE)
//  stop    in   1      command: abort sequence at next edge, no done pulse
//  div     in   DIV_W  prescale divisor, sampled only on an accepted start
//  len     in   LEN_W  number of enable pulses, sampled only on an accepted start
//  enable  out  1      one-cycle pulse to downstream counter enable, registered
//  busy    out  1      high while in RUN, registered
//  done    out  1      one-cycle pulse coinciding with the final enable of a burst
// BEHAVIOUR
//  - Reset: enable=0, busy=0, done=0, state=IDLE, prescaler=0, pulse count=0,
//    div_q=0, len_q=0. Reset mid-burst aborts it with no done pulse.
//  - States: IDLE, RUN. Two states only; done is a registered pulse, not a state.
//  - IDLE: start=1 and stop=0 at edge E0 -> div_q<=div, len_q<=len, pre<=0, cnt<=0,
//    state<=RUN, busy<=1. start together with stop in IDLE -> remain IDLE.
//  - RUN, each edge, priority order:
//    1. stop=1 -> state<=IDLE, busy<=0, enable<=0, done<=0. Stop wins over a terminal count.
//    2. pre==div_q -> pre<=0, enable<=1, cnt<=cnt+1.
//       If len_q!=0 and cnt+1==len_q -> state<=IDLE, busy<=0, done<=1.
//    3. Otherwise -> pre<=pre+1, enable<=0.
//  - Latency: the first enable is high in the cycle after edge E0+(div_q+1). Enable pulses
//    are then spaced exactly div_q+1 clocks apart.
//  - div_q=0 gives enable high every cycle while in RUN.
//  - done is high in the same cycle as the last enable, then clears. In all other cycles
//    enable and done are 0 unless rule 2 sets them.
//  - start while in RUN is ignored; div and len changes mid-burst have no effect.
//  - len_q=0: cnt wraps modulo 2**LEN_W, done is never raised, and the sequence ends
//    only on stop or reset.
//  - A new start is accepted on the edge after busy falls, with no dead cycle beyond
//    the IDLE cycle.
//  - pre is DIV_W bits wide and cnt is LEN_W bits wide; neither can overflow in a bounded
//    burst because both terminate before the wrap.
// STRUCTURE
//  - Shared package count_pkg:
//    - typedef enum {ST_IDLE, ST_RUN} ceg_state_t;
//    - default localparams CEG_DIV_W=8 and CEG_LEN_W=5, reused by the counter bench.
//  - One sub-module, tick_prescaler:
//    - inputs clear and load of div_q; output tick on pre==div_q.
//    - holds pre and the terminal compare.
//  - Top level holds the FSM, cnt, len_q, and the enable/busy/done registers.
// TESTING (bench clock period 10, reset held 2 cycles, check outputs 0 during reset)
//  1. start with div=3, len=4 -> enable high for 1 cycle at 4, 8, 12 and 16 clocks
//     after the start edge. done is high only with the 4th pulse; busy falls at the
//     same time. Downstream counter_out=4.
//  2. start with div=0, len=0, then stop 20 clocks later -> enable high on every cycle
//     from E0+1 through the stop edge. No done pulse. Counter wraps past 15 to 0..3.
//  3. start with div=2, len=5; assert stop on the edge where pre==div_q of pulse 2
//     -> pulse 2 is suppressed, busy=0, done=0.
//  4. start again during RUN with different div/len -> ignored; the original period
//     and count hold. start together with stop in IDLE -> busy stays 0.
//  5. reset asserted mid-burst (div=1, len=10, after pulse 3) -> next cycle all
//     outputs are 0. A fresh start with div=1, len=2 gives exactly 2 pulses and done.
//  6. back-to-back: start on the cycle after done -> accepted. Pulse spacing is
//     restored to div+1, with no stale pre or cnt values.

Source files
------------

// File: rtl/count_pkg.sv
// Shared types and default widths for the counter enable sequencer and its benches.
package count_pkg;

    typedef enum logic {ST_IDLE, ST_RUN} ceg_state_t;

    localparam int CEG_DIV_W = 8;
    localparam int CEG_LEN_W = 5;

endpackage

// File: rtl/tick_prescaler.sv
// Divides the clock by div_q+1: o_tick is high while the prescaler sits on div_q.
// Advances only when i_adv is high; load captures a new divisor and restarts the count.
module tick_prescaler
    import count_pkg::*;
#(
    parameter int DIV_W = CEG_DIV_W
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic             i_adv,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_pre;
    logic [DIV_W-1:0] r_div_q;
    logic             w_tick;

    assign w_tick = (r_pre == r_div_q);
    assign o_tick = w_tick;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_pre   <= '0;
            r_div_q <= '0;
        end else begin
            if (i_load) begin
                r_div_q <= i_div;
            end
            if (i_clear || i_load) begin
                r_pre <= '0;
            end else if (i_adv) begin
                r_pre <= w_tick ? '0 : r_pre + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/count_enable_gen.sv
// Emits registered one-cycle enable pulses every div+1 clocks for len pulses (0 = until stop).
// First enable follows the start edge by div+1 clocks; done rides on the final enable.
module count_enable_gen
    import count_pkg::*;
#(
    parameter int DIV_W = CEG_DIV_W,
    parameter int LEN_W = CEG_LEN_W
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic [DIV_W-1:0] i_div,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_enable,
    output logic             o_busy,
    output logic             o_done
);

    ceg_state_t       r_state;
    ceg_state_t       w_state_nxt;
    logic [LEN_W-1:0] r_cnt;
    logic [LEN_W-1:0] w_cnt_nxt;
    logic [LEN_W-1:0] w_cnt_inc;
    logic [LEN_W-1:0] r_len_q;
    logic [LEN_W-1:0] w_len_nxt;
    logic             r_enable;
    logic             r_busy;
    logic             r_done;
    logic             w_enable_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_accept;
    logic             w_run;
    logic             w_tick;

    assign w_run     = (r_state == ST_RUN);
    assign w_accept  = (r_state == ST_IDLE) && i_start && !i_stop;
    assign w_cnt_inc = r_cnt + LEN_W'(1);

    tick_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_clear (w_run && i_stop),
        .i_load  (w_accept),
        .i_adv   (w_run && !i_stop),
        .i_div   (i_div),
        .o_tick  (w_tick)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_len_nxt    = r_len_q;
        w_busy_nxt   = r_busy;
        w_enable_nxt = 1'b0;
        w_done_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_RUN;
                    w_busy_nxt  = 1'b1;
                    w_len_nxt   = i_len;
                    w_cnt_nxt   = '0;
                end
            end
            ST_RUN: begin
                // Stop outranks a terminal count landing on the same edge.
                if (i_stop) begin
                    w_state_nxt = ST_IDLE;
                    w_busy_nxt  = 1'b0;
                end else if (w_tick) begin
                    w_enable_nxt = 1'b1;
                    w_cnt_nxt    = w_cnt_inc;
                    if ((r_len_q != '0) && (w_cnt_inc == r_len_q)) begin
                        w_state_nxt = ST_IDLE;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_len_q  <= '0;
            r_enable <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_len_q  <= w_len_nxt;
            r_enable <= w_enable_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign o_enable = r_enable;
    assign o_busy   = r_busy;
    assign o_done   = r_done;

endmodule

// File: tb/tb_count_enable_gen.sv
// Directed bench: expected pulse edges are queued at each start and matched cycle by cycle.
module tb_count_enable_gen;
    import count_pkg::*;

    logic                 i_clock = 1'b0;
    logic                 i_reset = 1'b1;
    logic                 i_start = 1'b0;
    logic                 i_stop  = 1'b0;
    logic [CEG_DIV_W-1:0] i_div   = '0;
    logic [CEG_LEN_W-1:0] i_len   = '0;
    logic                 o_enable;
    logic                 o_busy;
    logic                 o_done;

    typedef struct {
        int cyc;
        bit dn;
    } exp_t;

    exp_t     exp_q[$];
    int       cyc    = 0;
    int       b_from = 0;
    int       b_to   = 0;
    int       e0     = 0;
    int       total  = 0;
    int       bad    = 0;
    logic [3:0] cnt4 = '0;

    count_enable_gen dut (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_start  (i_start),
        .i_stop   (i_stop),
        .i_div    (i_div),
        .i_len    (i_len),
        .o_enable (o_enable),
        .o_busy   (o_busy),
        .o_done   (o_done)
    );

    always #5 i_clock = ~i_clock;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // One clock edge, then compare every output against the queued expectation.
    task automatic tick();
        logic exp_en;
        logic exp_dn;
        @(posedge i_clock);
        #1;
        cyc++;
        while (exp_q.size() != 0 && exp_q[0].cyc < cyc) void'(exp_q.pop_front());
        exp_en = (exp_q.size() != 0) && (exp_q[0].cyc == cyc);
        exp_dn = exp_en ? exp_q[0].dn : 1'b0;
        if (exp_en) void'(exp_q.pop_front());
        chk("enable", {7'b0, o_enable}, {7'b0, exp_en});
        chk("done",   {7'b0, o_done},   {7'b0, exp_dn});
        chk("busy",   {7'b0, o_busy},   {7'b0, (cyc >= b_from) && (cyc < b_to)});
        if (o_enable === 1'b1) cnt4 = cnt4 + 4'd1;
    endtask

    // Start a burst on the next edge; npush pulses are expected, busy lasts end_off edges.
    task automatic launch(input int d, input int l, input int npush, input int end_off);
        e0 = cyc + 1;
        for (int k = 1; k <= npush; k++) begin
            exp_q.push_back('{cyc: e0 + k * (d + 1), dn: (l != 0) && (k == l)});
        end
        b_from  = e0;
        b_to    = e0 + end_off;
        i_start = 1'b1;
        i_div   = CEG_DIV_W'(d);
        i_len   = CEG_LEN_W'(l);
        tick();
        i_start = 1'b0;
        i_div   = CEG_DIV_W'($urandom);
        i_len   = CEG_LEN_W'($urandom);
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    initial begin
        // Reset held two cycles; all outputs must read 0.
        i_start = 1'b1;
        i_div   = 8'd5;
        i_len   = 5'd3;
        tick();
        tick();
        i_reset = 1'b0;
        i_start = 1'b0;
        tick();

        // 1: div=3 len=4 -> pulses at +4,+8,+12,+16, done on the last.
        cnt4 = '0;
        launch(3, 4, 4, 16);
        run_to(e0 + 18);
        chk("t1_counter", {4'b0, cnt4}, 8'd4);

        // 2: div=0 len=0, stop sampled at E0+20 -> 19 pulses, counter wraps to 3.
        cnt4 = '0;
        launch(0, 0, 19, 20);
        run_to(e0 + 19);
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        run_to(e0 + 24);
        chk("t2_counter", {4'b0, cnt4}, 8'd3);

        // 3: div=2 len=5, stop on the edge that would carry pulse 2.
        launch(2, 5, 1, 6);
        run_to(e0 + 5);
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        run_to(e0 + 10);

        // 4: restart attempt during RUN is ignored; start+stop in IDLE is ignored.
        launch(1, 3, 3, 6);
        run_to(e0 + 1);
        i_start = 1'b1;
        i_div   = 8'd4;
        i_len   = 5'd1;
        tick();
        i_start = 1'b0;
        run_to(e0 + 8);
        i_start = 1'b1;
        i_stop  = 1'b1;
        tick();
        i_start = 1'b0;
        i_stop  = 1'b0;
        run_to(cyc + 4);

        // 5: reset after pulse 3 of a div=1 len=10 burst, then a clean div=1 len=2 burst.
        launch(1, 10, 3, 7);
        run_to(e0 + 6);
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        tick();
        launch(1, 2, 2, 4);
        run_to(e0 + 4);

        // 6: back-to-back start on the edge right after done.
        launch(2, 3, 3, 9);
        run_to(e0 + 12);

        chk("queue_drained", 8'(exp_q.size()), 8'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
